// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA 640x480@60 timing constants and the decoder lock-state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_TOTAL     = 800;
    localparam int V_ACTIVE    = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_TOTAL     = 525;
    localparam int LOCK_FRAMES = 2;

    // Width of the recovered x/y coordinates.
    localparam int COORD_W     = 10;
    // Clocks from the generator driving a sync level to the registered edge pulse.
    localparam int EDGE_DLY    = 2;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } sync_state_t;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// VGA timing link bundle: sync inputs and err_clr toward the decoder, recovered timing back.
// Latency: n/a (wires only).
// Backpressure: none; sync link is free-running.
// Ports: vga_hsync_in/vga_vsync_in (active-low syncs), err_clr, x, y, active, line_start,
//        frame_start, locked, err_hperiod, err_vperiod.
interface vga_sync_decoder_if;
    import vga_timing_pkg::*;

    logic               vga_hsync_in;
    logic               vga_vsync_in;
    logic               err_clr;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
    logic               line_start;
    logic               frame_start;
    logic               locked;
    logic               err_hperiod;
    logic               err_vperiod;

    // Timing source / observer side.
    modport master (
        output vga_hsync_in, vga_vsync_in, err_clr,
        input  x, y, active, line_start, frame_start, locked, err_hperiod, err_vperiod
    );

    // Decoder side.
    modport slave (
        input  vga_hsync_in, vga_vsync_in, err_clr,
        output x, y, active, line_start, frame_start, locked, err_hperiod, err_vperiod
    );

endinterface

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Two-flop sampler for an active-low sync plus a registered assertion-edge pulse.
// Latency: edge_pulse is high 2 clocks after the source drives the sync low.
// Backpressure: none.
// Ports: clk_25, rst_n, sync_n (active-low sync in), edge_pulse (1-cycle pulse out).
module sync_edge_detect (
    input  logic clk_25,
    input  logic rst_n,
    input  logic sync_n,
    output logic edge_pulse
);

    logic s1;
    logic s2;

    // Samplers reset to the idle (high) level so release of reset never looks like an edge.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            edge_pulse <= 1'b0;
        end else begin
            s1         <= sync_n;
            s2         <= s1;
            edge_pulse <= !s1 && s2;
        end
    end

endmodule

// File: rtl/vga_sync_decoder.sv
// Locks to hsync/vsync timing and recovers x/y, active video and line/frame pulses.
// Latency: when locked x/y equal the generator's counters delayed by 2 clocks.
// Backpressure: none; errors are sticky until err_clr or reset.
// Ports: clk_25, rst_n, bus (slave side of vga_sync_decoder_if).
module vga_sync_decoder #(
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP        = vga_timing_pkg::H_FP,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP        = vga_timing_pkg::V_FP,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic              clk_25,
    input  logic              rst_n,
    vga_sync_decoder_if.slave bus
);
    import vga_timing_pkg::*;

    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    // The edge pulse arrives when x already sits on HS_START, so reload one position on.
    localparam logic [COORD_W-1:0] H_RELOAD = COORD_W'(H_ACTIVE + H_FP + EDGE_DLY - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_NEXT  = (V_ACTIVE + V_FP == V_TOTAL - 1) ?
                                              '0 : COORD_W'(V_ACTIVE + V_FP + 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [10:0]        H_PERIOD = 11'(H_TOTAL);
    localparam logic [9:0]         V_LINES  = 10'(V_TOTAL);
    localparam logic [3:0]         GOOD_REQ = 4'(LOCK_FRAMES);

    logic               h_edge;
    logic               v_edge;
    sync_state_t        state;
    logic [COORD_W-1:0] hcnt;
    logic [COORD_W-1:0] vcnt;
    logic [10:0]        pcnt;        // clocks since last hsync edge
    logic [9:0]         lcnt;        // hsync edges since last vsync edge
    logic [3:0]         good_frames;
    logic               h_valid;     // pcnt holds a real spacing (an edge seen in MEASURE)
    logic               v_seen;      // vsync edge seen on the current line
    logic               err_h;
    logic               err_v;

    logic               h_wrap;
    logic               line_adv;
    logic [COORD_W-1:0] hcnt_nxt;
    logic [COORD_W-1:0] vcnt_nxt;
    logic               h_bad;
    logic               v_bad;
    logic               frame_ok;
    logic               is_locked;

    sync_edge_detect u_hs_edge (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .sync_n     (bus.vga_hsync_in),
        .edge_pulse (h_edge)
    );

    sync_edge_detect u_vs_edge (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .sync_n     (bus.vga_vsync_in),
        .edge_pulse (v_edge)
    );

    // Position tracking runs in every state so x/y are already aligned at the moment of lock.
    always_comb begin
        h_wrap   = (hcnt == H_LAST);
        line_adv = h_wrap && !h_edge;
        hcnt_nxt = h_edge ? H_RELOAD : (h_wrap ? '0 : hcnt + 1'b1);

        vcnt_nxt = vcnt;
        if (v_edge) begin
            vcnt_nxt = line_adv ? VS_NEXT : VS_START;
        end else if (line_adv) begin
            vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
    end

    // Timing checks. Both syncs are evaluated independently in the same cycle.
    always_comb begin
        h_bad    = 1'b0;
        v_bad    = 1'b0;
        frame_ok = 1'b0;
        case (state)
            MEASURE: begin
                if (h_valid && h_edge && (pcnt != H_PERIOD)) h_bad = 1'b1;
                if (h_valid && !h_edge && (pcnt >= H_PERIOD)) h_bad = 1'b1;
                if (v_edge && (lcnt != V_LINES)) v_bad = 1'b1;
                if (h_edge && !v_edge && (lcnt >= V_LINES)) v_bad = 1'b1;
                frame_ok = v_edge && (lcnt == V_LINES);
            end
            LOCKED: begin
                h_bad = h_edge ? (hcnt != HS_START) : (hcnt == HS_START);
                // A missing vsync is caught at the end of the line it was due on.
                v_bad = (v_edge && (vcnt != VS_START)) ||
                        (!v_edge && !v_seen && h_wrap && (vcnt == VS_START));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            hcnt        <= '0;
            vcnt        <= '0;
            pcnt        <= '0;
            lcnt        <= '0;
            good_frames <= '0;
            h_valid     <= 1'b0;
            v_seen      <= 1'b0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
        end else begin
            hcnt   <= hcnt_nxt;
            vcnt   <= vcnt_nxt;
            v_seen <= h_wrap ? 1'b0 : (v_seen | v_edge);
            pcnt   <= h_edge ? 11'd1 : ((pcnt == 11'h7FF) ? pcnt : pcnt + 11'd1);
            if (v_edge) begin
                // An hsync edge in the same cycle belongs to the new frame.
                lcnt <= h_edge ? 10'd1 : 10'd0;
            end else if (h_edge && (lcnt != 10'h3FF)) begin
                lcnt <= lcnt + 10'd1;
            end

            // A new error beats a simultaneous clear.
            err_h <= (err_h & ~bus.err_clr) | h_bad;
            err_v <= (err_v & ~bus.err_clr) | v_bad;

            case (state)
                SEARCH: begin
                    h_valid <= h_edge;
                    if (v_edge) begin
                        state       <= MEASURE;
                        good_frames <= '0;
                    end
                end
                MEASURE: begin
                    if (h_edge) h_valid <= 1'b1;
                    if (h_bad || v_bad) begin
                        state <= SEARCH;
                    end else if (frame_ok) begin
                        good_frames <= good_frames + 4'd1;
                        if (good_frames + 4'd1 == GOOD_REQ) state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (h_bad || v_bad) state <= SEARCH;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign is_locked       = (state == LOCKED);
    assign bus.locked      = is_locked;
    assign bus.x           = is_locked ? hcnt : '0;
    assign bus.y           = is_locked ? vcnt : '0;
    assign bus.active      = is_locked && (hcnt < H_ACT) && (vcnt < V_ACT);
    assign bus.line_start  = is_locked && (hcnt == '0);
    assign bus.frame_start = is_locked && (hcnt == '0) && (vcnt == '0);
    assign bus.err_hperiod = err_h;
    assign bus.err_vperiod = err_v;

endmodule
